// File: rtl/config_chain_receiver.sv
// Sink for the ccff serial configuration stream: packs bits MSB-first into
// words, buffers them in a 2-entry show-ahead FIFO and flags load completion.
module config_chain_receiver #(
  parameter int unsigned CHAIN_LENGTH = 1024,
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH    = 11
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset_n,
  input  logic                  start,
  input  logic                  ccff_in,
  output logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  word_last,
  output logic [CNT_WIDTH-1:0]  bit_count,
  output logic                  overflow,
  output logic                  done
);

  localparam int unsigned          POS_W    = $clog2(WORD_WIDTH);
  localparam logic [POS_W-1:0]     POS_MAX  = POS_W'(WORD_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(CHAIN_LENGTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(CHAIN_LENGTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] shift_q;
  logic [POS_W-1:0]      pos_q;
  logic [WORD_WIDTH-1:0] skid_data;
  logic                  skid_last;
  logic                  skid_valid;

  logic                  clear_c;
  logic                  sample_c;
  logic                  word_end_c;
  logic                  pop_c;
  logic [WORD_WIDTH-1:0] shift_next_c;
  logic [WORD_WIDTH-1:0] push_data_c;
  logic                  push_last_c;

  // State register; done is registered off the next state.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q <= IDLE;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_d == DONE);
    end
  end

  // Next-state logic; dropping start aborts from any state.
  always_comb begin
    state_d  = state_q;
    clear_c  = 1'b0;
    sample_c = 1'b0;
    if (!start) begin
      state_d = IDLE;
      clear_c = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          clear_c = 1'b1;
          state_d = SHIFT;
        end
        SHIFT: begin
          sample_c = 1'b1;
          if (bit_count == LAST_BIT) state_d = DRAIN;
        end
        DRAIN: if (!word_valid) state_d = DONE;
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Word assembly: a word closes on its last bit or on the final chain bit,
  // the short final word is left-aligned with zero padding.
  always_comb begin
    shift_next_c = {shift_q[WORD_WIDTH-2:0], ccff_in};
    push_last_c  = (bit_count == LAST_BIT);
    word_end_c   = sample_c && ((pos_q == POS_MAX) || push_last_c);
    push_data_c  = shift_next_c << (POS_MAX - pos_q);
    pop_c        = word_valid && word_ready;
  end

  // Shift register, bit counter and 2-entry FIFO (output stage + skid entry).
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      shift_q    <= '0;
      pos_q      <= '0;
      bit_count  <= '0;
      word_data  <= '0;
      word_last  <= 1'b0;
      word_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      skid_valid <= 1'b0;
      overflow   <= 1'b0;
    end else if (clear_c) begin
      shift_q    <= '0;
      pos_q      <= '0;
      bit_count  <= '0;
      word_data  <= '0;
      word_last  <= 1'b0;
      word_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      skid_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (sample_c) begin
        if (bit_count != FULL_CNT) bit_count <= bit_count + CNT_WIDTH'(1);
        if (word_end_c) begin
          shift_q <= '0;
          pos_q   <= '0;
        end else begin
          shift_q <= shift_next_c;
          pos_q   <= pos_q + POS_W'(1);
        end
      end
      // Pop first so a push on the same edge can use the freed slot.
      if (pop_c) begin
        word_data  <= skid_data;
        word_last  <= skid_last;
        word_valid <= skid_valid;
        skid_valid <= 1'b0;
      end
      if (word_end_c) begin
        if (!word_valid || (pop_c && !skid_valid)) begin
          word_data  <= push_data_c;
          word_last  <= push_last_c;
          word_valid <= 1'b1;
        end else if (!skid_valid || pop_c) begin
          skid_data  <= push_data_c;
          skid_last  <= push_last_c;
          skid_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_config_chain_receiver.sv
// Self-checking bench: three receivers (chain lengths 16, 12, 24; 8-bit words)
// driven by a vector table, directed corner sequences and randomized loads.
module tb_config_chain_receiver;

  logic       clk;
  logic       rst_n;
  logic [2:0] st;
  logic       ccff;
  logic       rdy;
  logic [7:0] wd [3];
  logic       wv [3];
  logic       wl [3];
  logic       ov [3];
  logic       dn [3];
  logic [10:0] bc [3];

  int total  = 0;
  int passed = 0;

  config_chain_receiver #(.CHAIN_LENGTH(16), .WORD_WIDTH(8), .CNT_WIDTH(11)) u16 (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(st[0]), .ccff_in(ccff),
    .word_data(wd[0]), .word_valid(wv[0]), .word_ready(rdy), .word_last(wl[0]),
    .bit_count(bc[0]), .overflow(ov[0]), .done(dn[0]));

  config_chain_receiver #(.CHAIN_LENGTH(12), .WORD_WIDTH(8), .CNT_WIDTH(11)) u12 (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(st[1]), .ccff_in(ccff),
    .word_data(wd[1]), .word_valid(wv[1]), .word_ready(rdy), .word_last(wl[1]),
    .bit_count(bc[1]), .overflow(ov[1]), .done(dn[1]));

  config_chain_receiver #(.CHAIN_LENGTH(24), .WORD_WIDTH(8), .CNT_WIDTH(11)) u24 (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(st[2]), .ccff_in(ccff),
    .word_data(wd[2]), .word_valid(wv[2]), .word_ready(rdy), .word_last(wl[2]),
    .bit_count(bc[2]), .overflow(ov[2]), .done(dn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       s;
    logic       b;
    logic       r;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    int         ec;
    logic       edn;
  } vec_t;

  typedef struct packed {
    logic       l;
    logic [7:0] d;
  } ent_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int k, input string tag, input logic v, input logic [7:0] d,
                            input logic l, input int c, input logic dne, input logic ove);
    chk({tag, " valid"}, 32'(wv[k]), 32'(v));
    if (v) begin
      chk({tag, " data"}, 32'(wd[k]), 32'(d));
      chk({tag, " last"}, 32'(wl[k]), 32'(l));
    end
    chk({tag, " bit_count"}, 32'(bc[k]), 32'(c));
    chk({tag, " done"}, 32'(dn[k]), 32'(dne));
    chk({tag, " overflow"}, 32'(ov[k]), 32'(ove));
  endtask

  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ccff = val[i];
      tick();
    end
  endtask

  task automatic go_idle(input int k);
    st[k] = 1'b0;
    tick();
    expect_out(k, "idle", 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Randomized load checked against a queue-based model of the protocol rules.
  task automatic run_rand(input int k, input int cl, input int iters);
    bit   bits [32];
    ent_t words [4];
    ent_t q [$];
    int   nw, ks, bias, cyc;
    logic ovm, dnm, pre_v, pop;
    for (int it = 0; it < iters; it++) begin
      nw = (cl + 7) / 8;
      for (int i = 0; i < cl; i++) bits[i] = 1'($urandom_range(0, 1));
      for (int j = 0; j < nw; j++) begin
        words[j].d = 8'h00;
        words[j].l = (j == nw - 1);
        for (int b = 0; b < 8; b++)
          if (j * 8 + b < cl) words[j].d[7 - b] = bits[j * 8 + b];
      end
      q.delete();
      ks = 0; ovm = 1'b0; dnm = 1'b0; cyc = 0;
      bias = $urandom_range(0, 2);
      rdy = 1'($urandom_range(0, 1));
      st[k] = 1'b1;
      tick();
      expect_out(k, "rand arm", 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
      while (!dnm && cyc < 200) begin
        rdy  = ($urandom_range(0, 3) <= bias);
        ccff = (ks < cl) ? bits[ks] : 1'($urandom_range(0, 1));
        pre_v = (q.size() > 0);
        pop   = pre_v && rdy;
        if (ks == cl && !pre_v) dnm = 1'b1;
        if (pop) void'(q.pop_front());
        if (ks < cl) begin
          ks++;
          if (ks % 8 == 0 || ks == cl) begin
            if (q.size() < 2) q.push_back(words[(ks - 1) / 8]);
            else ovm = 1'b1;
          end
        end
        tick();
        cyc++;
        if (q.size() > 0)
          expect_out(k, $sformatf("rand k%0d it%0d cyc%0d", k, it, cyc), 1'b1, q[0].d, q[0].l, ks, dnm, ovm);
        else
          expect_out(k, $sformatf("rand k%0d it%0d cyc%0d", k, it, cyc), 1'b0, 8'h00, 1'b0, ks, dnm, ovm);
      end
      if (!dnm) chk("rand completion within budget", 32'(0), 32'(1));
      go_idle(k);
    end
  endtask

  vec_t tbl [19];

  initial begin
    // Chain of 16, ready held high: 0xA5 then 0x3C, then two edges to done.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0,  1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1,  1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2,  1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3,  1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4,  1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5,  1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 6,  1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 7,  1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 8,  1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 9,  1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 10, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 11, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 12, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 13, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 14, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 15, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 16, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16, 1'b1};

    rst_n = 1'b0; st = 3'b000; ccff = 1'b0; rdy = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      expect_out(k, "por", 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
      chk("por word_data", 32'(wd[k]), 32'(0));
    end
    rst_n = 1'b1;
    tick();

    // Table-driven nominal load.
    for (int i = 0; i < 19; i++) begin
      st[0] = tbl[i].s; ccff = tbl[i].b; rdy = tbl[i].r;
      tick();
      expect_out(0, $sformatf("table row%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].el,
                 tbl[i].ec, tbl[i].edn, 1'b0);
    end
    go_idle(0);

    // Async reset in the middle of a load.
    rdy = 1'b0; st[0] = 1'b1;
    tick();
    send_bits(32'h296, 10);
    expect_out(0, "pre-reset", 1'b1, 8'hA5, 1'b0, 10, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    expect_out(0, "async reset", 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    chk("async reset word_data", 32'(wd[0]), 32'(0));
    chk("async reset word_last", 32'(wl[0]), 32'(0));
    st[0] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Partial final word, left-aligned.
    rdy = 1'b1; st[1] = 1'b1;
    tick();
    send_bits(32'hFF, 8);
    expect_out(1, "partial w0", 1'b1, 8'hFF, 1'b0, 8, 1'b0, 1'b0);
    send_bits(32'hF, 4);
    expect_out(1, "partial w1", 1'b1, 8'hF0, 1'b1, 12, 1'b0, 1'b0);
    tick();
    expect_out(1, "partial drain", 1'b0, 8'h00, 1'b0, 12, 1'b0, 1'b0);
    tick();
    expect_out(1, "partial done", 1'b0, 8'h00, 1'b0, 12, 1'b1, 1'b0);
    go_idle(1);

    // Backpressure: third word dropped, drain resumes when ready returns.
    rdy = 1'b0; st[2] = 1'b1;
    tick();
    send_bits(32'h11, 8);
    expect_out(2, "bp w0", 1'b1, 8'h11, 1'b0, 8, 1'b0, 1'b0);
    send_bits(32'h22, 8);
    expect_out(2, "bp hold", 1'b1, 8'h11, 1'b0, 16, 1'b0, 1'b0);
    send_bits(32'h33, 8);
    expect_out(2, "bp drop", 1'b1, 8'h11, 1'b0, 24, 1'b0, 1'b1);
    ccff = 1'b1;
    tick();
    tick();
    expect_out(2, "bp stall", 1'b1, 8'h11, 1'b0, 24, 1'b0, 1'b1);
    rdy = 1'b1;
    tick();
    expect_out(2, "bp pop1", 1'b1, 8'h22, 1'b0, 24, 1'b0, 1'b1);
    tick();
    expect_out(2, "bp pop2", 1'b0, 8'h00, 1'b0, 24, 1'b0, 1'b1);
    tick();
    expect_out(2, "bp done", 1'b0, 8'h00, 1'b0, 24, 1'b1, 1'b1);
    rdy = 1'b0;
    go_idle(2);

    // Ready pulsed on the third push edge: pop then push, nothing lost.
    st[2] = 1'b1;
    tick();
    send_bits(32'h44, 8);
    send_bits(32'h55, 8);
    send_bits(32'h33, 7);
    ccff = 1'b0; rdy = 1'b1;
    tick();
    rdy = 1'b0;
    expect_out(2, "pulse push", 1'b1, 8'h55, 1'b0, 24, 1'b0, 1'b0);
    tick();
    expect_out(2, "pulse hold", 1'b1, 8'h55, 1'b0, 24, 1'b0, 1'b0);
    rdy = 1'b1;
    tick();
    expect_out(2, "pulse w2", 1'b1, 8'h66, 1'b1, 24, 1'b0, 1'b0);
    tick();
    expect_out(2, "pulse empty", 1'b0, 8'h00, 1'b0, 24, 1'b0, 1'b0);
    tick();
    expect_out(2, "pulse done", 1'b0, 8'h00, 1'b0, 24, 1'b1, 1'b0);
    go_idle(2);

    // Abort after 5 bits, then a clean restart.
    rdy = 1'b1; st[0] = 1'b1;
    tick();
    send_bits(32'h1F, 5);
    expect_out(0, "abort pre", 1'b0, 8'h00, 1'b0, 5, 1'b0, 1'b0);
    st[0] = 1'b0;
    tick();
    expect_out(0, "abort idle", 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    st[0] = 1'b1; rdy = 1'b0;
    tick();
    expect_out(0, "restart arm", 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    send_bits(32'hA5, 8);
    expect_out(0, "restart w0", 1'b1, 8'hA5, 1'b0, 8, 1'b0, 1'b0);
    go_idle(0);

    run_rand(1, 12, 10);
    run_rand(2, 24, 10);
    run_rand(0, 16, 6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
